// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
//   Shared sizing and FSM encoding for the nn_node datapath and its loader.
//   Keeping the geometry here guarantees the loader's vector layout and the
//   consumer's slicing agree.
//   Contents: word geometry (DATA_W, N_IN, N_HID, N_OUT), derived frame size
//   N_TOT, word-counter width, FSM state constants, word type.
//   Optional feature macro used by the loader: NN_LOADER_WEIGHT_HOLD_EN.
// -----------------------------------------------------------------------------
package nn_pkg;

    localparam int DATA_W = 16;
    localparam int N_IN   = 4;
    localparam int N_HID  = 4;
    localparam int N_OUT  = 2;

    localparam int N_W1   = N_IN * N_HID;
    localparam int N_W2   = N_HID * N_OUT;
    localparam int N_TOT  = N_IN + N_W1 + N_W2;

    // One bit of headroom over N_TOT so overlong frames are still counted
    // (saturating) and can be told apart from the last legal slot.
    localparam int K_W    = $clog2(N_TOT + 1) + 1;
    localparam int CNT_W  = 16;

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_FIRE = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/nn_loader_if.sv
// -----------------------------------------------------------------------------
// nn_loader_if
//   Valid/ready word stream into nn_loader.
//   s_data  : stream word
//   s_valid : s_data valid
//   s_last  : final word of the frame, qualified by s_valid
//   s_ready : loader accepts a word this cycle
//   master modport = stream source, slave modport = loader.
// -----------------------------------------------------------------------------
interface nn_loader_if;
    import nn_pkg::*;

    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;

    modport master (output s_data, output s_valid, output s_last, input s_ready);
    modport slave  (input s_data, input s_valid, input s_last, output s_ready);

endinterface

// File: rtl/nn_loader_ctrl.sv
// -----------------------------------------------------------------------------
// nn_loader_ctrl
//   Frame control for nn_loader: LOAD/FIRE/HOLD FSM, word counter, hold
//   counter and last-word decode. Produces one-hot slot write enables for the
//   register file in the parent.
//   Ports:
//     clk, rst_n    clock, async active-low reset
//     s_valid_i     stream valid
//     s_last_i      stream last
//     s_ready_o     registered "in LOAD" decode
//     slot_we_o     one-hot write enable for slot k (only when k < N_TOT)
//     in_ready_o    one-cycle pulse while in FIRE
//     frame_err_o   one-cycle pulse after a malformed frame is dropped
//     frame_cnt_o   count of in_ready pulses, wrapping
//   Macro NN_LOADER_WEIGHT_HOLD_EN: accept N_IN-word frames that reuse the
//   held weights once a full frame has loaded them.
// -----------------------------------------------------------------------------
module nn_loader_ctrl
    import nn_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid_i,
    input  logic             s_last_i,
    output logic             s_ready_o,
    output logic [N_TOT-1:0] slot_we_o,
    output logic             in_ready_o,
    output logic             frame_err_o,
    output logic [CNT_W-1:0] frame_cnt_o
);

    localparam int HW = $clog2(HOLD_CYCLES) + 1;

    logic [1:0]       state_q, state_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             s_ready_q;
    logic             in_ready_q;
    logic             frame_err_q;
    logic [CNT_W-1:0] frame_cnt_q;

    logic hs;
    logic last_full;
    logic fire;
    logic err;

    // s_ready is only ever high in LOAD, so a handshake implies LOAD.
    assign hs        = s_valid_i && s_ready_q;
    assign last_full = (k_q == K_W'(N_TOT - 1));

`ifdef NN_LOADER_WEIGHT_HOLD_EN
    logic wt_loaded_q, wt_loaded_d;
    logic last_short;

    assign last_short = (k_q == K_W'(N_IN - 1));
`endif

    always_comb begin
        fire = 1'b0;
        err  = 1'b0;
        if (hs && s_last_i) begin
            if (last_full) begin
                fire = 1'b1;
`ifdef NN_LOADER_WEIGHT_HOLD_EN
            end else if (last_short && wt_loaded_q) begin
                fire = 1'b1;
`endif
            end else begin
                err = 1'b1;
            end
        end
    end

`ifdef NN_LOADER_WEIGHT_HOLD_EN
    // Weights are trusted only after a complete frame and until any error,
    // since an aborted frame may have overwritten part of them.
    always_comb begin
        wt_loaded_d = wt_loaded_q;
        if (err)
            wt_loaded_d = 1'b0;
        else if (fire && last_full)
            wt_loaded_d = 1'b1;
    end
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        hold_d  = hold_q;
        case (state_q)
            ST_LOAD: begin
                if (fire) begin
                    state_d = ST_FIRE;
                    k_d     = '0;
                end else if (err) begin
                    k_d = '0;
                end else if (hs && (k_q != {K_W{1'b1}})) begin
                    k_d = k_q + K_W'(1);
                end
            end
            ST_FIRE: begin
                state_d = ST_HOLD;
                k_d     = '0;
                hold_d  = HW'(HOLD_CYCLES - 1);
            end
            ST_HOLD: begin
                if (hold_q == '0)
                    state_d = ST_LOAD;
                else
                    hold_d = hold_q - HW'(1);
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            k_q         <= '0;
            hold_q      <= '0;
            s_ready_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
`ifdef NN_LOADER_WEIGHT_HOLD_EN
            wt_loaded_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            hold_q      <= hold_d;
            s_ready_q   <= (state_d == ST_LOAD);
            in_ready_q  <= fire;
            frame_err_q <= err;
            if (fire)
                frame_cnt_q <= frame_cnt_q + CNT_W'(1);
`ifdef NN_LOADER_WEIGHT_HOLD_EN
            wt_loaded_q <= wt_loaded_d;
`endif
        end
    end

    // Words past N_TOT match no slot and are dropped.
    for (genvar i = 0; i < N_TOT; i++) begin : g_we
        assign slot_we_o[i] = hs && (k_q == K_W'(i));
    end

    assign s_ready_o   = s_ready_q;
    assign in_ready_o  = in_ready_q;
    assign frame_err_o = frame_err_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: rtl/nn_loader.sv
// -----------------------------------------------------------------------------
// nn_loader
//   Upstream feeder for nn_node. Collects a frame of DATA_W words (inputs,
//   layer-1 weights, layer-2 weights) from a valid/ready stream into a
//   register file, pulses in_ready when the frame is complete and keeps the
//   registers frozen through the consumer's pipeline (FIRE + HOLD_CYCLES).
//   Ports:
//     clk, rst_n  clock, async active-low reset
//     s           nn_loader_if.slave stream (s_data/s_valid/s_last/s_ready)
//     in_vec      word i = in<i>, word 0 at LSBs
//     w1_vec      word i*N_HID+h = weight input i -> hidden h
//     w2_vec      word h*N_OUT+o = weight hidden h -> output o
//     in_ready    one-cycle pulse, vectors hold a complete frame
//     frame_err   one-cycle pulse, malformed frame dropped
//     frame_cnt   count of in_ready pulses, wrapping
//   Macro NN_LOADER_WEIGHT_HOLD_EN: short (N_IN-word) frames refresh in_vec
//   only and reuse the held weights.
// -----------------------------------------------------------------------------
module nn_loader
    import nn_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    nn_loader_if.slave                s,
    output logic [N_IN*DATA_W-1:0]    in_vec,
    output logic [N_W1*DATA_W-1:0]    w1_vec,
    output logic [N_W2*DATA_W-1:0]    w2_vec,
    output logic                      in_ready,
    output logic                      frame_err,
    output logic [CNT_W-1:0]          frame_cnt
);

    logic [N_TOT-1:0]  slot_we;
    logic              s_ready_w;
    word_t [N_TOT-1:0] words_q;

    nn_loader_ctrl #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid_i   (s.s_valid),
        .s_last_i    (s.s_last),
        .s_ready_o   (s_ready_w),
        .slot_we_o   (slot_we),
        .in_ready_o  (in_ready),
        .frame_err_o (frame_err),
        .frame_cnt_o (frame_cnt)
    );

    assign s.s_ready = s_ready_w;

    // Slots are only written in LOAD, so everything stays frozen through
    // FIRE and HOLD without an explicit freeze signal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_q <= '0;
        end else begin
            for (int i = 0; i < N_TOT; i++)
                if (slot_we[i])
                    words_q[i] <= s.s_data;
        end
    end

    assign in_vec = words_q[N_IN-1:0];
    assign w1_vec = words_q[N_IN+N_W1-1:N_IN];
    assign w2_vec = words_q[N_TOT-1:N_IN+N_W1];

endmodule

// File: tb/tb_nn_loader.sv
// -----------------------------------------------------------------------------
// tb_nn_loader
//   Directed + randomized bench for nn_loader with a frame-level reference
//   model. Honours NN_LOADER_WEIGHT_HOLD_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_nn_loader;
    import nn_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    nn_loader_if bus();

    logic [N_IN*DATA_W-1:0] in_vec;
    logic [N_W1*DATA_W-1:0] w1_vec;
    logic [N_W2*DATA_W-1:0] w2_vec;
    logic                   in_ready;
    logic                   frame_err;
    logic [CNT_W-1:0]       frame_cnt;

    nn_loader #(.HOLD_CYCLES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s         (bus),
        .in_vec    (in_vec),
        .w1_vec    (w1_vec),
        .w2_vec    (w2_vec),
        .in_ready  (in_ready),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int ir_cnt = 0;
    int fe_cnt = 0;

    logic [DATA_W-1:0] stim [64];
    logic [DATA_W-1:0] m_words [N_TOT];
    logic [CNT_W-1:0]  m_cnt;
    int                m_pulses = 0;
    int                m_errs   = 0;
    bit                m_wt;

    // Pulse counters: sampled at the active edge, so each pulse counts once.
    always @(posedge clk) begin
        if (in_ready === 1'b1)  ir_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- reference model (frame level) ----------------
    task automatic model_reset();
        for (int i = 0; i < N_TOT; i++) m_words[i] = '0;
        m_cnt = '0;
        m_wt  = 1'b0;
    endtask

    task automatic model_frame(input int n, output bit good);
        for (int i = 0; i < n && i < N_TOT; i++) m_words[i] = stim[i];
        good = (n == N_TOT);
`ifdef NN_LOADER_WEIGHT_HOLD_EN
        if (n == N_IN && m_wt) good = 1'b1;
`endif
        if (good) begin
            m_cnt++;
            m_pulses++;
            if (n == N_TOT) m_wt = 1'b1;
        end else begin
            m_wt = 1'b0;
            m_errs++;
        end
    endtask

    task automatic check_vectors(input string tag);
        logic [N_TOT*DATA_W-1:0] all;
        for (int i = 0; i < N_TOT; i++) all[i*DATA_W +: DATA_W] = m_words[i];
        chk({tag, "_in_vec"}, in_vec, all[N_IN*DATA_W-1:0]);
        chk({tag, "_w1_vec"}, w1_vec, all[(N_IN+N_W1)*DATA_W-1:N_IN*DATA_W]);
        chk({tag, "_w2_vec"}, w2_vec, all[N_TOT*DATA_W-1:(N_IN+N_W1)*DATA_W]);
    endtask

    // ---------------- stimulus ----------------
    task automatic fill_seq();
        for (int i = 0; i < 64; i++) stim[i] = DATA_W'(i + 1);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 64; i++) stim[i] = DATA_W'($urandom);
    endtask

    // Entered and left at a falling edge; s_ready is registered, so its
    // value at the falling edge is what the next rising edge sees.
    task automatic send_frame(input int n, input bit bubbles);
        for (int i = 0; i < n; i++) begin
            int t;
            if (bubbles) begin
                int g;
                g = $urandom_range(0, 2);
                bus.s_valid = 1'b0;
                repeat (g) @(negedge clk);
            end
            bus.s_data  = stim[i];
            bus.s_valid = 1'b1;
            bus.s_last  = (i == n - 1);
            t = 0;
            while (bus.s_ready !== 1'b1 && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) begin
                chk("send_timeout", 1'b1, 1'b0);
                bus.s_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    // Called at the first falling edge after the last word's handshake.
    task automatic post_frame(input string tag, input bit good);
        int n;
        if (good) begin
            chk({tag, "_in_ready"}, in_ready, 1'b1);
            chk({tag, "_err_low"}, frame_err, 1'b0);
            @(negedge clk);
            chk({tag, "_in_ready_1cyc"}, in_ready, 1'b0);
            n = 1;
            while (bus.s_ready !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk({tag, "_ready_low_cycles"}, n, 3);
        end else begin
            chk({tag, "_frame_err"}, frame_err, 1'b1);
            chk({tag, "_no_in_ready"}, in_ready, 1'b0);
            @(negedge clk);
            chk({tag, "_err_1cyc"}, frame_err, 1'b0);
            chk({tag, "_ready_after_err"}, bus.s_ready, 1'b1);
        end
        chk({tag, "_frame_cnt"}, frame_cnt, m_cnt);
        chk({tag, "_pulses"}, ir_cnt, m_pulses);
        chk({tag, "_errs"}, fe_cnt, m_errs);
    endtask

    initial begin
        bit good;
        logic [DATA_W-1:0] w;

        rst_n       = 1'b0;
        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_in_vec", in_vec, '0);
        chk("rst_w1_vec", w1_vec, '0);
        chk("rst_w2_vec", w2_vec, '0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_frame_cnt", frame_cnt, '0);
        chk("rst_s_ready", bus.s_ready, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_s_ready", bus.s_ready, 1'b1);

        // A: sequential words 1..N_TOT, valid held high
        fill_seq();
        model_frame(N_TOT, good);
        send_frame(N_TOT, 1'b0);
        post_frame("A", good);
        chk("A_in_vec_const", in_vec, 64'h0004_0003_0002_0001);
        w = w1_vec[DATA_W-1:0];
        chk("A_w1_word0", w, 16'd5);
        w = w2_vec[7*DATA_W +: DATA_W];
        chk("A_w2_word7", w, 16'd28);
        check_vectors("A");

        // B: same frame with random bubbles
        model_frame(N_TOT, good);
        send_frame(N_TOT, 1'b1);
        post_frame("B", good);
        check_vectors("B");

        // C: random data with bubbles
        fill_rand();
        model_frame(N_TOT, good);
        send_frame(N_TOT, 1'b1);
        post_frame("C", good);
        check_vectors("C");

        // D: early s_last on word 10, then a good frame
        fill_rand();
        model_frame(10, good);
        send_frame(10, 1'b0);
        post_frame("D_err", good);
        fill_rand();
        model_frame(N_TOT, good);
        send_frame(N_TOT, 1'b1);
        post_frame("D_good", good);
        check_vectors("D_good");

        // E: late s_last on word 31; words past N_TOT must not land anywhere
        fill_rand();
        model_frame(31, good);
        send_frame(31, 1'b0);
        post_frame("E_err", good);
        w = w2_vec[7*DATA_W +: DATA_W];
        chk("E_w2_word7", w, m_words[N_TOT-1]);
        check_vectors("E");
        fill_rand();
        model_frame(N_TOT, good);
        send_frame(N_TOT, 1'b0);
        post_frame("E_good", good);

        // F: short frame after a good full frame
        fill_rand();
        model_frame(N_IN, good);
        send_frame(N_IN, 1'b0);
        post_frame("F_short", good);
        check_vectors("F");

        // G: reset mid-stream, then a short frame straight after reset
        fill_rand();
        for (int i = 0; i < 5; i++) begin
            bus.s_data  = stim[i];
            bus.s_valid = 1'b1;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("G_rst_in_vec", in_vec, '0);
        chk("G_rst_w1_vec", w1_vec, '0);
        chk("G_rst_w2_vec", w2_vec, '0);
        chk("G_rst_frame_cnt", frame_cnt, '0);
        chk("G_rst_s_ready", bus.s_ready, 1'b0);
        bus.s_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("G_rel_s_ready", bus.s_ready, 1'b1);
        fill_rand();
        model_frame(N_IN, good);
        send_frame(N_IN, 1'b0);
        post_frame("G_short", good);
        fill_rand();
        model_frame(N_TOT, good);
        send_frame(N_TOT, 1'b1);
        post_frame("G_good", good);
        check_vectors("G_good");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
